uart_cmd_responder: RTL

Device-side command engine for the board's serial control link. Parses byte commands arriving from the UART receiver, updates a bank of 32-bit output port registers on WRITE, and returns 32-bit input port values through the UART transmitter on READ. Sits between the UART core and the sensor datapath (sine generator enables, filter length, phase settings, result readback).

---
 rtl/uart_cmd_responder.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder
//
// Device-side command engine for the serial control link.
//
// Bytes from the UART receiver are parsed as commands:
//   WRITE (opcode 4'b0010): four data bytes follow, MSB first. They update
//                           one 32-bit output port register.
//   READ  (opcode 4'b0011): the selected input port is captured and returned
//                           as four bytes through the UART transmitter,
//                           MSB first.
// Any other opcode is silently dropped.
//
// Ports:
//   clk100M    in   1     master clock, 100 MHz
//   reset_n    in   1     asynchronous reset. Active HIGH despite the name.
//   rx_data    in   8     received byte, valid while rx_ready=1
//   rx_ready   in   1     one-cycle pulse, new byte on rx_data
//   tx_data    out  8     byte to transmit, held until the next tx_en
//   tx_en      out  1     one-cycle pulse, start transmission of tx_data
//   tx_ready   in   1     transmitter idle and able to accept a byte
//   out_ports  out  32*N  register bank, port k at bits [32k+31:32k]
//   out_wr     out  1     one-cycle pulse, a port register was updated
//   out_addr   out  4     port index of the last write
//   in_addr    out  4     select for the external input port mux
//   in_data    in   32    selected input port value
//   busy       out  1     high whenever the engine is not idle
// ---------------------------------------------------------------------------
module uart_cmd_responder #(
    parameter int NUM_OUT_PORTS  = 10,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                       clk100M,
    input  logic                       reset_n,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_en,
    input  logic                       tx_ready,
    output logic [32*NUM_OUT_PORTS-1:0] out_ports,
    output logic                       out_wr,
    output logic [3:0]                 out_addr,
    output logic [3:0]                 in_addr,
    input  logic [31:0]                in_data,
    output logic                       busy
);

    localparam logic [3:0] OP_WRITE = 4'b0010;
    localparam logic [3:0] OP_READ  = 4'b0011;

    // The timeout counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_CAPTURE,
        RD_SEND,
        RD_WAIT
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [3:0]      cmd_port;
    logic [2:0]      byte_cnt;
    logic [31:0]     assembly;
    logic [31:0]     tx_shift;
    logic [TW-1:0]   timeout_cnt;
    logic [31:0]     port_regs [NUM_OUT_PORTS];

    logic            start_write;
    logic            start_read;
    logic            take_byte;
    logic            commit;
    logic            capture;
    logic            tx_fire;
    logic            timeout_hit;
    logic            port_ok;
    logic [31:0]     write_word;

    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
    assign port_ok     = (int'(cmd_port) < NUM_OUT_PORTS);

    // State register.
    always_ff @(posedge clk100M or posedge reset_n) begin
        if (reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // In RD_WAIT, tx_en is high for exactly the first cycle. During that
    // cycle the transmitter may not have dropped tx_ready yet, so tx_ready
    // is ignored while tx_en is still high.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_write) begin
                    state_next = WR_DATA;
                end else if (start_read) begin
                    state_next = RD_CAPTURE;
                end
            end
            WR_DATA: begin
                if (commit) begin
                    state_next = IDLE;
                end else if (!rx_ready && timeout_hit) begin
                    state_next = IDLE;
                end
            end
            RD_CAPTURE: begin
                state_next = RD_SEND;
            end
            RD_SEND: begin
                if (tx_fire) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!tx_en && tx_ready) begin
                    state_next = (byte_cnt == 3'd4) ? IDLE : RD_SEND;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: per-state strobes that steer the datapath.
    // rx_ready is only acted on in IDLE and WR_DATA. Bytes that arrive
    // during a read response are dropped because the link is half-duplex.
    always_comb begin
        start_write = 1'b0;
        start_read  = 1'b0;
        take_byte   = 1'b0;
        commit      = 1'b0;
        capture     = 1'b0;
        tx_fire     = 1'b0;
        write_word  = {assembly[23:0], rx_data};
        case (state)
            IDLE: begin
                start_write = rx_ready && (rx_data[7:4] == OP_WRITE);
                start_read  = rx_ready && (rx_data[7:4] == OP_READ);
            end
            WR_DATA: begin
                take_byte = rx_ready;
                commit    = rx_ready && (byte_cnt == 3'd3);
            end
            RD_CAPTURE: begin
                capture = 1'b1;
            end
            RD_SEND: begin
                tx_fire = tx_ready;
            end
            default: begin
            end
        endcase
    end

    // Command datapath.
    // byte_cnt is shared by both directions: it counts data bytes received
    // on a write and bytes handed to the transmitter on a read.
    always_ff @(posedge clk100M or posedge reset_n) begin
        if (reset_n) begin
            cmd_port    <= '0;
            byte_cnt    <= '0;
            assembly    <= '0;
            tx_shift    <= '0;
            timeout_cnt <= '0;
            in_addr     <= '0;
        end else begin
            if (start_write || start_read) begin
                cmd_port <= rx_data[3:0];
                byte_cnt <= '0;
            end else if (take_byte || tx_fire) begin
                byte_cnt <= byte_cnt + 3'd1;
            end

            if (start_read) begin
                in_addr <= rx_data[3:0];
            end

            if (start_write) begin
                assembly <= '0;
            end else if (take_byte) begin
                assembly <= write_word;
            end

            if (capture) begin
                tx_shift <= in_data;
            end else if (tx_fire) begin
                tx_shift <= {tx_shift[23:0], 8'h00};
            end

            if (rx_ready || (state != WR_DATA)) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end
        end
    end

    // Registered outputs toward the UART and the sensor datapath.
    // busy is derived from state_next so that it tracks the state register
    // exactly.
    always_ff @(posedge clk100M or posedge reset_n) begin
        if (reset_n) begin
            tx_data  <= '0;
            tx_en    <= 1'b0;
            out_wr   <= 1'b0;
            out_addr <= '0;
            busy     <= 1'b0;
        end else begin
            tx_en  <= tx_fire;
            out_wr <= commit && port_ok;
            busy   <= (state_next != IDLE);
            if (tx_fire) begin
                tx_data <= tx_shift[31:24];
            end
            if (commit && port_ok) begin
                out_addr <= cmd_port;
            end
        end
    end

    // Output register bank.
    // A write to a port beyond the bank matches no entry, so the word is
    // dropped.
    always_ff @(posedge clk100M or posedge reset_n) begin
        if (reset_n) begin
            for (int k = 0; k < NUM_OUT_PORTS; k++) begin
                port_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT_PORTS; k++) begin
                if (commit && (cmd_port == 4'(k))) begin
                    port_regs[k] <= write_word;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_flatten
        assign out_ports[32*g +: 32] = port_regs[g];
    end

endmodule
